// File: rtl/mem_port_arbiter.sv
// Shares the single unified memory port between instruction fetch and data access (LWD/SWD).
// Optional grant/conflict counters are compiled in with the ARB_STAT_EN macro.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
`ifdef ARB_STAT_EN
  output logic [STAT_W-1:0] n_i_grant,
  output logic [STAT_W-1:0] n_d_grant,
  output logic [STAT_W-1:0] n_conflict,
`endif
  output logic              busy
);

  // state  | meaning
  // IDLE   | no transaction; grant evaluated each edge, data first
  // D_BUSY | load/store command on the port until m_ack
  // I_BUSY | fetch command on the port until m_ack
  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

  state_t state;
  logic   cancel_q;
  logic   d_any;

  assign d_any = d_read | d_write;

  // Responses are combinational on m_ack so the requester sees data in the ack cycle.
  assign d_ready = (state == D_BUSY) && m_ack;
  assign i_ready = (state == I_BUSY) && m_ack && !cancel_q && !i_cancel;
  assign d_rdata = d_ready ? m_rdata : '0;
  assign i_data  = i_ready ? m_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      m_read   <= 1'b0;
      m_write  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      busy     <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_any) begin
            state   <= D_BUSY;
            m_read  <= d_read;
            m_write <= d_write;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            busy    <= 1'b1;
          end else if (i_req && !i_cancel) begin
            state    <= I_BUSY;
            m_read   <= 1'b1;
            m_write  <= 1'b0;
            m_addr   <= i_addr;
            busy     <= 1'b1;
            cancel_q <= 1'b0;
          end
        end
        D_BUSY: begin
          if (m_ack) begin
            state   <= IDLE;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            busy    <= 1'b0;
          end
        end
        I_BUSY: begin
          // A flush never aborts memory; it only suppresses the response.
          if (m_ack) begin
            state    <= IDLE;
            m_read   <= 1'b0;
            busy     <= 1'b0;
            cancel_q <= 1'b0;
          end else if (i_cancel) begin
            cancel_q <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          m_read   <= 1'b0;
          m_write  <= 1'b0;
          busy     <= 1'b0;
          cancel_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STAT_EN
  localparam logic [STAT_W-1:0] STAT_ONE = 1;

  // Fetch grants are counted at delivery so cancelled fetches are excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_i_grant  <= '0;
      n_d_grant  <= '0;
      n_conflict <= '0;
    end else begin
      if (i_ready && (n_i_grant != '1))
        n_i_grant <= n_i_grant + STAT_ONE;
      if ((state == IDLE) && d_any && (n_d_grant != '1))
        n_d_grant <= n_d_grant + STAT_ONE;
      if ((state == IDLE) && d_any && i_req && (n_conflict != '1))
        n_conflict <= n_conflict + STAT_ONE;
    end
  end
`else
  // Counters compiled out; STAT_W stays so instantiations do not depend on the build.
  if (STAT_W < 1) begin : g_stat_w_unused
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level reference model plus
// a randomized memory responder; monitors compare commands and responses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_cancel, i_ready;
  logic [15:0] i_addr, i_data;
  logic        d_read, d_write, d_ready;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        m_read, m_write, m_ack;
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic        busy;
`ifdef ARB_STAT_EN
  logic [15:0] n_i_grant, n_d_grant, n_conflict;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STAT_W(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel), .i_ready(i_ready), .i_data(i_data),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
`ifdef ARB_STAT_EN
    .n_i_grant(n_i_grant), .n_d_grant(n_d_grant), .n_conflict(n_conflict),
`endif
    .busy(busy)
  );

  typedef struct packed {
    logic        is_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t        cmd_q[$];
  txn_t        rsp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] mem[256];
  logic [15:0] ref_mem[256];
  int          forced_lat = 0;
  bit          hold_ack = 1'b0;
  bit          stray_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic fail_now(input string name, input string what);
    n_total++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Memory responder: acks after 1..4 command cycles, or never while hold_ack is set.
  initial begin
    int cnt;
    int lat;
    cnt = 0; lat = 1;
    m_ack = 1'b0; m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      if (stray_ack) begin
        m_ack = 1'b1; m_rdata = 16'($urandom); stray_ack = 1'b0;
      end else if (reset || !(m_read || m_write)) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 1) lat = (forced_lat != 0) ? forced_lat : $urandom_range(1, 4);
        if (!hold_ack && cnt >= lat) begin
          m_ack = 1'b1;
          if (m_write) begin
            mem[m_addr[7:0]] = m_wdata;
            m_rdata = 16'($urandom);
          end else begin
            m_rdata = mem[m_addr[7:0]];
          end
        end
      end
    end
  end

  // Monitor: commands against cmd_q, ready pulses against rsp_q.
  initial begin
    bit          active;
    bit          prev_rdy;
    logic [32:0] held;
    txn_t        exp;
    active = 1'b0; prev_rdy = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (prev_rdy) begin
        chk("turnaround_busy", busy, 0);
        chk("turnaround_cmd", {m_read, m_write}, 0);
      end
      prev_rdy = i_ready | d_ready;
      if (m_read || m_write) begin
        if (!active) begin
          active = 1'b1;
          held = {m_write, m_addr, m_wdata};
          chk("cmd_onehot", m_read & m_write, 0);
          if (cmd_q.size() == 0) fail_now("cmd_unexpected", $sformatf("addr %0h", m_addr));
          else begin
            exp = cmd_q.pop_front();
            chk("cmd_op", m_write, exp.wr);
            chk("cmd_addr", m_addr, exp.addr);
            if (exp.wr) chk("cmd_wdata", m_wdata, exp.data);
          end
        end else begin
          chk("cmd_stable", {m_write, m_addr, m_wdata}, held);
        end
      end else begin
        active = 1'b0;
      end
      if (i_ready || d_ready) begin
        chk("rdy_exclusive", i_ready & d_ready, 0);
        chk("rdy_with_ack", m_ack, 1);
        if (rsp_q.size() == 0) fail_now("rsp_unexpected", $sformatf("i_ready %0b d_ready %0b", i_ready, d_ready));
        else begin
          exp = rsp_q.pop_front();
          chk("rsp_side", d_ready, exp.is_d);
          if (!exp.wr) chk(exp.is_d ? "d_rdata" : "i_data", exp.is_d ? d_rdata : i_data, exp.data);
        end
      end
    end
  end

  // cmode: 0 normal, 1 i_cancel with i_req in IDLE, 2 i_cancel in first fetch command cycle.
  task automatic run(input bit has_d, input bit d_wr, input logic [15:0] da, input logic [15:0] dw,
                     input bit has_i, input logic [15:0] ia, input int cmode);
    bit pend_d, pend_i, gd, gi;
    @(posedge clk); #1;
    if (has_d) begin
      cmd_q.push_back('{1'b1, d_wr, da, dw});
      if (d_wr) begin
        ref_mem[da[7:0]] = dw;
        rsp_q.push_back('{1'b1, 1'b1, da, 16'h0});
      end else begin
        rsp_q.push_back('{1'b1, 1'b0, da, ref_mem[da[7:0]]});
      end
    end
    if (has_i && cmode != 1) begin
      cmd_q.push_back('{1'b0, 1'b0, ia, 16'h0});
      if (cmode == 0) rsp_q.push_back('{1'b0, 1'b0, ia, ref_mem[ia[7:0]]});
    end
    d_read = has_d & ~d_wr; d_write = has_d & d_wr; d_addr = da; d_wdata = dw;
    i_req = has_i; i_addr = ia; i_cancel = (cmode == 1);
    pend_d = has_d;
    pend_i = has_i && (cmode == 0);
    if (cmode == 1) begin
      @(posedge clk); #1;
      i_req = 1'b0; i_cancel = 1'b0;
    end
    if (cmode == 2) begin
      @(posedge clk); #1;
      i_cancel = 1'b1; i_req = 1'b0;
      @(posedge clk); #1;
      i_cancel = 1'b0;
    end
    for (int c = 0; c < 80 && (pend_d || pend_i); c++) begin
      @(negedge clk);
      gd = d_ready; gi = i_ready;
      @(posedge clk); #1;
      if (gd) begin d_read = 1'b0; d_write = 1'b0; pend_d = 1'b0; end
      if (gi) begin i_req = 1'b0; pend_i = 1'b0; end
    end
    if (pend_d || pend_i) begin
      fail_now("timeout", $sformatf("pending d %0b i %0b", pend_d, pend_i));
      d_read = 1'b0; d_write = 1'b0; i_req = 1'b0;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          k;
    logic [15:0] da, dw, ia;
    bit          wr;
    reset = 1'b1;
    i_req = 0; i_addr = 0; i_cancel = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 16'h6A05; ref_mem[8'h10] = 16'h6A05;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", {m_read, m_write}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {i_ready, d_ready}, 0);
    chk("rst_addr_wdata", {m_addr, m_wdata}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single fetch, ack in the first command cycle.
    forced_lat = 1;
    cmd_q.push_back('{1'b0, 1'b0, 16'h0010, 16'h0});
    rsp_q.push_back('{1'b0, 1'b0, 16'h0010, 16'h6A05});
    i_req = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    chk("f_req_cycle_mread", m_read, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("f_mread", m_read, 1);
    chk("f_maddr", m_addr, 16'h0010);
    chk("f_iready", i_ready, 1);
    chk("f_idata", i_data, 16'h6A05);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    chk("f_busy_after", busy, 0);
    chk("f_iready_after", i_ready, 0);
    @(posedge clk); #1;

    // Conflict: data first, fetch after turnaround.
    forced_lat = 0;
    run(1, 0, 16'h0100, 16'h0, 1, 16'h0020, 0);
    // Store held for 3 cycles.
    forced_lat = 3;
    run(1, 1, 16'h0040, 16'hBEEF, 0, 16'h0, 0);
    chk("store_mem", mem[8'h40], 16'hBEEF);
    // Cancel in the command cycle before the ack, then a normal fetch.
    forced_lat = 2;
    run(0, 0, 16'h0, 16'h0, 1, 16'h0050, 2);
    forced_lat = 0;
    run(0, 0, 16'h0, 16'h0, 1, 16'h0030, 0);

    // Reset during D_BUSY, stray ack afterwards, then a normal load.
    hold_ack = 1'b1;
    cmd_q.push_back('{1'b1, 1'b0, 16'h0200, 16'h0});
    d_read = 1'b1; d_addr = 16'h0200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; d_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_cmd", {m_read, m_write}, 0);
    chk("rst_mid_busy", busy, 0);
    stray_ack = 1'b1; hold_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run(1, 0, 16'h0200, 16'h0, 0, 16'h0, 0);

    repeat (200) begin
      k = $urandom_range(0, 5);
      da = 16'($urandom); dw = 16'($urandom); ia = 16'($urandom);
      wr = 1'($urandom_range(0, 1));
      case (k)
        0: run(0, 0, 16'h0, 16'h0, 1, ia, 0);
        1: run(1, 0, da, dw, 0, 16'h0, 0);
        2: run(1, 1, da, dw, 0, 16'h0, 0);
        3: run(1, wr, da, dw, 1, ia, 0);
        4: run(0, 0, 16'h0, 16'h0, 1, ia, 2);
        default: run(1'($urandom_range(0, 1)), wr, da, dw, 1, ia, 1);
      endcase
    end

    repeat (3) @(posedge clk);
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
